usr_shift_engine: RTL
=====================

Name: usr_shift_engine

Overview:
Parametrised universal shift register, WIDTH bits wide. Supports hold, single-bit logical shifts, parallel load, rotate by amount, and arithmetic shift right by amount. Adds a serialiser burst: a start pulse loads a word and shifts it out MSB-first under a busy/done handshake. Serves as the general-purpose shift/serialise block for datapath and serial-link logic.

Parameters:
WIDTH, 8, register width in bits; minimum 2.
SHAMT_W, $clog2(WIDTH), shift-amount width. Derived localparam, not overridable.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
en  input  1  mode-operation enable; has no effect on a running burst.
mode  input  3  operation select (see Behaviour).
shamt  input  SHAMT_W  shift/rotate amount for modes 100/101/110.
data_in  input  WIDTH  parallel load / burst load word.
s_left_in  input  1  serial bit inserted at LSB on left shifts and burst shifts.
s_right_in  input  1  serial bit inserted at MSB on mode-010 right shift.
start  input  1  burst request, sampled in IDLE only.
data_out  output  WIDTH  register contents.
ser_out  output  1  burst serial bit = data_out[WIDTH-1] while busy, else 0 (combinational).
busy  output  1  high during a burst.
done  output  1  registered one-cycle pulse after the final burst bit.

Behaviour:
- Reset: data_out=0, busy=0, done=0, counter=0, FSM=IDLE, asynchronously, with no clock edge required.
- All shifts operate on the current data_out contents, never on data_in. Only mode 011 and burst start read data_in.
- FSM states: IDLE, BURST.
- In IDLE, a rising clock edge with start=1 has priority over mode and en:
  - data_out<=data_in, counter<=0, busy<=1, go to BURST.
- In IDLE with start=0 and en=1, modes update data_out at the clock edge, 1-cycle latency:
  - 000: hold.
  - 001: shift left 1, {data_out[WIDTH-2:0], s_left_in}.
  - 010: shift right 1, {s_right_in, data_out[WIDTH-1:1]}.
  - 011: parallel load data_in.
  - 100: rotate left by (shamt mod WIDTH).
  - 101: rotate right by (shamt mod WIDTH).
  - 110: arithmetic shift right by shamt; MSB replicated; shamt>=WIDTH gives all bits = old MSB.
  - 111: hold (reserved).
- In IDLE with en=0: hold.
- BURST, each edge:
  - data_out<={data_out[WIDTH-2:0], s_left_in}, counter++.
  - When counter==WIDTH-1 at the edge: go to IDLE, busy<=0, done<=1.
  - Result: WIDTH bits presented on ser_out over exactly WIDTH cycles, MSB first.
  - mode, en and start are ignored during BURST; start is not queued.
- done is high exactly one cycle, then returns to 0. A start in that same cycle is accepted (back-to-back bursts allowed).
- Reset asserted mid-burst aborts the burst: busy=0 and no done pulse.
- shamt=0 in modes 100/101/110 is a hold.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: modes 100/101 rotate as specified, and the barrel rotator is instantiated.
- Undefined: modes 100/101 behave as hold and the rotator is not built. Mode 110 (ASR) is always present.

Decomposition:
- Package usr_pkg holds:
  - mode encodings as localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_ASR, MODE_RSVD.
  - FSM state encodings: ST_IDLE, ST_BURST.
- One natural sub-module: usr_barrel_rotator. It is combinational, parametrised by WIDTH, and takes data, shamt and direction, returning the rotated word. It is instantiated only under USR_ROTATE_EN.

Test Plan (WIDTH=8):
1. Assert rst between clock edges while data_out=0xA5 -> data_out=0x00, busy=0, done=0 immediately. Release rst, then mode 000 -> stays 0x00.
2. Mode 011, data_in=0xA5 -> 0xA5. Mode 001, s_left_in=1 -> 0x4B. Mode 010, s_right_in=0 -> 0x25. Mode 011 with en=0 -> stays 0x25.
3. Load 0x81. Mode 100, shamt=3 -> 0x0C. Mode 101, shamt=3 -> 0x81. With USR_ROTATE_EN undefined, mode 100 -> stays 0x81.
4. Load 0x90. Mode 110, shamt=2 -> 0xE4. Load 0x90, mode 110, shamt=7 -> 0xFF. Load 0x70, mode 110, shamt=7 -> 0x00.
5. start with data_in=0xC3, s_left_in=0 -> ser_out 1,1,0,0,0,0,1,1 over 8 cycles; busy high 8 cycles; done one cycle; final data_out=0x00. A start pulse and mode=011 at cycle 3 are ignored. A start in the done cycle begins a new burst.
6. Burst of 0xFF with rst asserted during cycle 4 -> busy=0, data_out=0x00 at once; done never pulses. After release, the IDLE mode 011 operation works normally.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the universal shift engine.
//   - MODE_* : 3-bit operation selects for IDLE-state mode operations.
//   - state_e: burst FSM states (ST_IDLE, ST_BURST).
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/usr_barrel_rotator.sv
// usr_barrel_rotator: combinational rotate of a WIDTH-bit word.
// Ports:
//   data_i  [WIDTH]   word to rotate
//   shamt_i [SHAMT_W] rotate amount, taken modulo WIDTH
//   dir_i             0 = rotate left, 1 = rotate right
//   data_o  [WIDTH]   rotated word
module usr_barrel_rotator #(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               dir_i,
  output logic [WIDTH-1:0]   data_o
);

  int unsigned amt;

  // For amt == 0 the complementary shift is by WIDTH, which yields zero,
  // so the OR collapses to the unrotated word without a special case.
  always_comb begin
    amt = 32'(shamt_i) % WIDTH;
    if (dir_i) begin
      data_o = (data_i >> amt) | (data_i << (WIDTH - amt));
    end else begin
      data_o = (data_i << amt) | (data_i >> (WIDTH - amt));
    end
  end

endmodule

// File: rtl/usr_shift_engine.sv
// usr_shift_engine: WIDTH-bit universal shift register with a serialiser burst.
// Optional feature macro: USR_ROTATE_EN (enables modes 100/101 rotate and the
// barrel rotator; when undefined those modes hold).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         enables IDLE mode operations (ignored during a burst)
//   mode [3]   operation select (see usr_pkg MODE_*)
//   shamt      rotate / arithmetic-shift amount
//   data_in    parallel-load and burst-load word
//   s_left_in  bit entering LSB on left shifts and burst shifts
//   s_right_in bit entering MSB on single right shift
//   start      burst request, sampled in IDLE only
//   data_out   register contents
//   ser_out    MSB of data_out while busy, else 0
//   busy       high while a burst is running
//   done       one-cycle pulse after the final burst bit
// Handshake: start is accepted on any IDLE edge (including the done cycle);
// busy rises on that edge and stays high for exactly WIDTH cycles, during
// which ser_out carries the loaded word MSB first; done pulses for one cycle
// on the edge that drops busy. A start while busy is dropped, not queued.
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               s_left_in,
  input  logic               s_right_in,
  input  logic               start,
  output logic [WIDTH-1:0]   data_out,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

`ifdef USR_ROTATE_EN
  logic [WIDTH-1:0] rot_data;

  usr_barrel_rotator #(.WIDTH(WIDTH)) u_rot (
    .data_i  (data_q),
    .shamt_i (shamt),
    .dir_i   (mode == MODE_ROR),
    .data_o  (rot_data)
  );
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_BURST;
        end else if (en) begin
          case (mode)
            MODE_SHL:  data_d = {data_q[WIDTH-2:0], s_left_in};
            MODE_SHR:  data_d = {s_right_in, data_q[WIDTH-1:1]};
            MODE_LOAD: data_d = data_in;
`ifdef USR_ROTATE_EN
            MODE_ROL,
            MODE_ROR:  data_d = rot_data;
`endif
            // Signed shift replicates the MSB; amounts >= WIDTH saturate to
            // all-MSB, which is the required behaviour for non-power-of-2 WIDTH.
            MODE_ASR:  data_d = $unsigned($signed(data_q) >>> shamt);
            default:   data_d = data_q;
          endcase
        end
      end
      ST_BURST: begin
        data_d = {data_q[WIDTH-2:0], s_left_in};
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ser_out  = busy_q ? data_q[WIDTH-1] : 1'b0;

endmodule
